// File: rtl/ram_fifo_ctrl.sv
// First-word-fall-through FIFO controller around an external 1-cycle-latency RAM.
// A 2-entry prefetch buffer hides the read latency so push and pop can both run every cycle.
module ram_fifo_ctrl #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  clr,
    input  logic                  w_valid,
    output logic                  w_ready,
    input  logic [DATA_WIDTH-1:0] w_data,
    output logic                  r_valid,
    input  logic                  r_ready,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic [ADDR_WIDTH+1:0] level,
    output logic [ADDR_WIDTH-1:0] ram_a_addr,
    input  logic [DATA_WIDTH-1:0] ram_a_rddata,
    output logic [ADDR_WIDTH-1:0] ram_b_addr,
    output logic                  ram_b_we,
    output logic [DATA_WIDTH-1:0] ram_b_wrdata
);

    localparam int PW = ADDR_WIDTH + 1;

    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         ram_cnt;
    logic                  inflight;
    logic [1:0]            buf_cnt;
    logic [DATA_WIDTH-1:0] buf0;
    logic [DATA_WIDTH-1:0] buf1;
    logic                  push;
    logic                  pop;
    logic                  fetch;
    logic [2:0]            claim;

    assign ram_cnt = wr_ptr - rd_ptr;

    // The RAM is full exactly when the pointer difference reaches 2**ADDR_WIDTH.
    assign w_ready = !ram_cnt[ADDR_WIDTH] && !clr;
    assign push    = w_valid && w_ready;
    assign r_valid = (buf_cnt != 2'd0);
    assign r_data  = buf0;
    assign pop     = r_valid && r_ready;

    // Buffer slots already claimed after this edge; a fetch needs one free slot for its word.
    assign claim = {1'b0, buf_cnt} + {2'b00, inflight} - {2'b00, pop};
    assign fetch = (ram_cnt != '0) && (claim <= 3'd1) && !clr;

    assign ram_b_we     = push;
    assign ram_b_addr   = wr_ptr[ADDR_WIDTH-1:0];
    assign ram_b_wrdata = w_data;
    assign ram_a_addr   = rd_ptr[ADDR_WIDTH-1:0];

    assign level = {1'b0, ram_cnt}
                 + {{(ADDR_WIDTH+1){1'b0}}, inflight}
                 + {{ADDR_WIDTH{1'b0}}, buf_cnt};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            inflight <= 1'b0;
            buf_cnt  <= 2'd0;
            buf0     <= '0;
            buf1     <= '0;
        end else if (clr) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            inflight <= 1'b0;
            buf_cnt  <= 2'd0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (fetch)
                rd_ptr <= rd_ptr + PW'(1);
            inflight <= fetch;

            // A landing word and a pop in the same cycle leave the occupancy unchanged.
            case ({inflight, pop})
                2'b10: begin
                    if (buf_cnt == 2'd0)
                        buf0 <= ram_a_rddata;
                    else
                        buf1 <= ram_a_rddata;
                    buf_cnt <= buf_cnt + 2'd1;
                end
                2'b01: begin
                    buf0    <= buf1;
                    buf_cnt <= buf_cnt - 2'd1;
                end
                2'b11: begin
                    if (buf_cnt == 2'd1) begin
                        buf0 <= ram_a_rddata;
                    end else begin
                        buf0 <= buf1;
                        buf1 <= ram_a_rddata;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/ram_fifo_ctrl.md
# ram_fifo_ctrl

First-word-fall-through FIFO controller that sequences one external `simple_rw_ram` instance. The write side drives the RAM's B (write) port and the read side drives its A (read) port. A 2-entry prefetch buffer hides the RAM's 1-cycle read latency, so the FIFO sustains one push and one pop per cycle. It sits between any valid/ready producer and consumer that need deeper buffering than flops allow.

## Interface
- `ADDR_WIDTH`, 16: RAM address width; RAM holds 2**ADDR_WIDTH words.
- `DATA_WIDTH`, 64: data width; must match the RAM instance.
- `clk`  in  1  clock; RAM shares it.
- `rstn`  in  1  reset. One clock; reset is asynchronous and active-low.
- `clr`  in  1  synchronous flush; empties the FIFO at the next edge.
- `w_valid`  in  1  producer has data.
- `w_ready`  out  1  FIFO accepts data.
- `w_data`  in  DATA_WIDTH  write data.
- `r_valid`  out  1  `r_data` holds the FIFO head.
- `r_ready`  in  1  consumer takes the head.
- `r_data`  out  DATA_WIDTH  head data, registered.
- `level`  out  ADDR_WIDTH+2  total entries held: RAM entries, plus the in-flight read, plus buffer entries.
- `ram_a_addr`  out  ADDR_WIDTH  to RAM `a_addr`.
- `ram_a_rddata`  in  DATA_WIDTH  from RAM `a_rddata`.
- `ram_b_addr`  out  ADDR_WIDTH  to RAM `b_addr`.
- `ram_b_we`  out  1  to RAM `b_we`.
- `ram_b_wrdata`  out  DATA_WIDTH  to RAM `b_wrdata`.

## Operation
- **State**
  - `wr_ptr`, `rd_ptr`: ADDR_WIDTH+1 bits each, wrap modulo 2**(ADDR_WIDTH+1). `rd_ptr` is the next RAM address to fetch.
  - `inflight`: 1 bit.
  - Prefetch buffer: 2 entries, `buf_cnt` 0..2, FIFO-ordered.
- **Derived signals**
  - `ram_cnt = wr_ptr - rd_ptr`, range 0..2**ADDR_WIDTH.
  - `push = w_valid & w_ready`.
  - `pop = r_valid & r_ready`.
- **Write side**
  - `w_ready = (ram_cnt != 2**ADDR_WIDTH) & !clr`.
  - `ram_b_we = push`, `ram_b_addr = wr_ptr[ADDR_WIDTH-1:0]`, `ram_b_wrdata = w_data`. All are combinational.
  - On `push`: `wr_ptr += 1`.
- **Fetch**
  - `ram_a_addr = rd_ptr[ADDR_WIDTH-1:0]` at all times.
  - `fetch = (ram_cnt != 0) & (buf_cnt + inflight - pop <= 1) & !clr`.
  - On `fetch`: `rd_ptr += 1`. `inflight` next = `fetch`.
- **Land**
  - When `inflight` = 1, `ram_a_rddata` is appended to the buffer at that edge.
  - A land and a pop in the same cycle are both applied, so `buf_cnt` is unchanged.
- **Read side**
  - `r_valid = buf_cnt != 0`.
  - `r_data` is buffer entry 0.
  - On `pop`, entry 1 shifts to entry 0.
- **Level**: `level = ram_cnt + inflight + buf_cnt`. Maximum capacity is 2**ADDR_WIDTH + 2.
- **Full / empty**
  - A push is refused only when the RAM holds 2**ADDR_WIDTH entries.
  - The buffer can never overflow, because the fetch condition reserves space for the in-flight word.
- **Address conflict**
  - Fetch requires `ram_cnt != 0`, so a fetched slot was always written at an earlier edge. The RAM's same-cycle old-data read behaviour is therefore never exercised.
  - A slot freed by a fetch may be rewritten from the next cycle onward.
- **`clr`**
  - Takes effect at the next edge: pointers, `inflight` and `buf_cnt` go to 0. RAM contents are not touched.
  - `clr` beats a simultaneous push, fetch or pop. `w_ready` is 0 while `clr` is high.
- **Reset** (`rstn` low, asynchronous): pointers = 0, `inflight` = 0, `buf_cnt` = 0, buffer data = 0.
  - Resulting outputs: `r_valid` = 0, `r_data` = 0, `level` = 0.
  - `w_ready` = 1 once `clr` = 0.
  - A reset mid-stream discards all data.

## Timing
- **Write to read latency**: a word pushed at edge E0 is fetched at E1, lands at E2, and `r_valid` is 1 from E2 onward. That is 2 cycles when the FIFO was empty.
- **Throughput**: sustained 1 push and 1 pop per cycle with no bubbles once `buf_cnt` ≥ 1.
- **Ready paths**
  - `w_ready` depends only on registers and `clr`.
  - `r_ready` affects only `fetch`. There is no combinational path from `r_ready` to `r_valid` or to `w_ready`.
- **Level update**: `level` is updated at the same edge as the pointer and buffer changes.

## Test plan
- **Reset defaults**: assert `rstn`=0 mid-stream with 5 entries held → immediately `r_valid`=0, `level`=0. After release, `w_ready`=1.
- **Single word latency**: with the FIFO empty, push 0xA5 at edge E0 → `ram_b_we`=1 with `ram_b_addr`=0. `r_valid` rises after E2 with `r_data`=0xA5. `level` reads 1 throughout.
- **Fill with consumer stalled**: ADDR_WIDTH=2, `r_ready`=0, push 1..8 continuously → 6 words are accepted and `w_ready` drops after the 6th. `level`=6. Popping one word raises `w_ready` the next cycle.
- **Streaming**: push and pop every cycle over 20 words, including pointer wrap at ADDR_WIDTH=2 → output is in order with no bubbles after the first word. `level` stays constant.
- **Flush**: with 4 entries held, pulse `clr` together with `w_valid`=1 and `r_ready`=1 → nothing is accepted or popped, and `level`=0 and `r_valid`=0 next cycle.
- **Random stress**: random `w_valid`/`r_ready` over 10k cycles, checked against a scoreboard model → data order correct, `level` matches the model, `ram_b_we` never asserted while full.
